lr_stack: RTL
=============

Name: lr_stack

Overview:
- Hardware return-address stack that sits beside the link register on the consuming side.
- On a nested call, it saves the outgoing link register value. On a return, it supplies the saved value back, with a one-cycle write pulse used as the link register's write enable and data.
- It is a circular buffer with saturating occupancy and sticky overflow/underflow flags, so deep recursion degrades gracefully instead of corrupting state.

Parameters:
- DEPTH, 8, number of 16-bit entries; must be a power of two, at least 2.
- AW, 3, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- push  input  1  call in progress: save lr_in this cycle.
- pop  input  1  return in progress: restore the top entry.
- lr_in  input  16  current link register value to save on push.
- clr_flags  input  1  clears the overflow and underflow sticky flags.
- lr_out  output  16  restored link register value.
- lr_wr_en  output  1  one-cycle pulse; link register loads lr_out when high.
- depth_count  output  AW+1  number of valid entries, 0..DEPTH.
- empty  output  1  depth_count == 0 (combinational from count).
- full  output  1  depth_count == DEPTH (combinational from count).
- overflow  output  1  sticky: a push occurred while full.
- underflow  output  1  sticky: a pop occurred while empty (without push).

Behaviour:
- Reset (rst low, asynchronous):
  - sp = 0, depth_count = 0, lr_out = 0, lr_wr_en = 0, overflow = 0, underflow = 0.
  - Storage contents are don't-care.
  - Reset mid-operation abandons any pending restore: no lr_wr_en pulse is issued after rst is released.
- Storage: circular array mem[0..DEPTH-1].
  - sp points to the next free slot; the top entry is at mem[sp-1] mod DEPTH.
  - The pointer wraps naturally at AW bits.
- Latency: restore is registered. The cycle after an accepted pop, lr_wr_en = 1 and lr_out = popped value.
- lr_wr_en is high for exactly one cycle per accepted pop. lr_out holds its last value otherwise.
- Push only (push=1, pop=0):
  - mem[sp] <= lr_in; sp <= sp+1.
  - If not full: depth_count increments.
  - If full: the write overwrites the oldest entry (same slot due to wrap), depth_count stays DEPTH, and overflow <= 1.
- Pop only (push=0, pop=1):
  - If not empty: lr_out <= mem[sp-1]; sp <= sp-1; depth_count decrements; lr_wr_en pulses next cycle.
  - If empty: no state change except underflow <= 1. lr_wr_en stays 0 and lr_out is unchanged.
- Push and pop in the same cycle (tail call / swap):
  - If not empty: lr_out <= old top; mem[sp-1] <= lr_in; sp and depth_count unchanged; lr_wr_en pulses.
  - If empty: bypass. lr_out <= lr_in, lr_wr_en pulses, memory/sp/count unchanged, no underflow.
  - If full: treated as the not-empty case; no overflow.
- Flags:
  - clr_flags=1 clears both overflow and underflow.
  - A set event in the same cycle as clr_flags wins, so the flag reads 1 next cycle.
- Arithmetic: sp is AW-bit modulo. depth_count is AW+1 bits, saturating at DEPTH, never below 0.
- Outputs lr_out, lr_wr_en, depth_count, overflow and underflow are registered; empty and full are decoded from depth_count.

Test Plan:
- Reset then idle: hold rst low 2 cycles, release -> lr_out=0, lr_wr_en=0, depth_count=0, empty=1, full=0, flags 0.
- Push then pop order:
  - Stimulus: push 0x1111, 0x2222, 0x3333 on consecutive cycles, then pop three times.
  - Required: lr_wr_en pulses each cycle after each pop, with lr_out = 0x3333, 0x2222, 0x1111; depth_count 3->0; empty=1 at end.
- Overflow wrap:
  - Stimulus: push 9 values 0x0001..0x0009 (DEPTH=8).
  - Required: full=1, depth_count=8, overflow=1.
  - Then 8 pops return 0x0009 down to 0x0002; 0x0001 is lost.
- Underflow and clear:
  - Stimulus: pop while empty.
  - Required: lr_wr_en stays 0, lr_out unchanged, underflow=1.
  - Then clr_flags for 1 cycle -> underflow=0.
  - Then clr_flags together with an empty pop -> underflow=1.
- Simultaneous push and pop:
  - Stack holds [0xAAAA]; push+pop with lr_in=0xBBBB -> next cycle lr_out=0xAAAA, lr_wr_en=1, depth_count=1.
  - A following pop returns 0xBBBB.
  - On an empty stack, push+pop with lr_in=0xCCCC -> lr_out=0xCCCC, lr_wr_en=1, depth_count=0, underflow=0.
- Asynchronous reset mid-operation:
  - Stimulus: pop with 2 entries present, then assert rst low between clock edges, before the next rising edge.
  - Required: lr_wr_en=0, depth_count=0 and lr_out=0 immediately.
  - No pulse after rst is released.

Source files
------------

// File: rtl/lr_stack_if.sv
// rtl/lr_stack_if.sv - call/return control and link-register restore signals of the return-address stack
interface lr_stack_if #(
    parameter int AW = 3
);
    logic          push;
    logic          pop;
    logic [15:0]   lr_in;
    logic          clr_flags;
    logic [15:0]   lr_out;
    logic          lr_wr_en;
    logic [AW:0]   depth_count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;

    modport master (
        output push, pop, lr_in, clr_flags,
        input  lr_out, lr_wr_en, depth_count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, lr_in, clr_flags,
        output lr_out, lr_wr_en, depth_count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/lr_stack.sv
// rtl/lr_stack.sv - circular return-address stack with registered link-register restore and sticky flags
module lr_stack #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clk,
    input  logic        rst,
    lr_stack_if.slave   bus
);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   COUNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] SP_ONE     = {{(AW-1){1'b0}}, 1'b1};

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] sp;
    logic [AW-1:0] top;
    logic [AW:0]   count;
    logic [15:0]   lr_out_q;
    logic          lr_wr_en_q;
    logic          overflow_q;
    logic          underflow_q;
    logic          is_empty;
    logic          is_full;
    logic          push_only;
    logic          pop_only;
    logic          swap;
    logic          set_overflow;
    logic          set_underflow;

    assign top           = sp - SP_ONE;
    assign is_empty      = (count == '0);
    assign is_full       = (count == FULL_COUNT);
    assign push_only     = bus.push & ~bus.pop;
    assign pop_only      = bus.pop & ~bus.push;
    assign swap          = bus.push & bus.pop;
    assign set_overflow  = push_only & is_full;
    assign set_underflow = pop_only & is_empty;

    // A push while full lands on the oldest slot because sp has wrapped onto it.
    always_ff @(posedge clk) begin
        if (push_only)
            mem[sp] <= bus.lr_in;
        else if (swap && !is_empty)
            mem[top] <= bus.lr_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp          <= '0;
            count       <= '0;
            lr_out_q    <= '0;
            lr_wr_en_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            lr_wr_en_q <= 1'b0;
            if (push_only) begin
                sp <= sp + SP_ONE;
                if (!is_full)
                    count <= count + COUNT_ONE;
            end else if (pop_only && !is_empty) begin
                lr_out_q   <= mem[top];
                lr_wr_en_q <= 1'b1;
                sp         <= top;
                count      <= count - COUNT_ONE;
            end else if (swap) begin
                // Tail call on an empty stack forwards the new link value straight through.
                lr_out_q   <= is_empty ? bus.lr_in : mem[top];
                lr_wr_en_q <= 1'b1;
            end
            overflow_q  <= (overflow_q  & ~bus.clr_flags) | set_overflow;
            underflow_q <= (underflow_q & ~bus.clr_flags) | set_underflow;
        end
    end

    assign bus.lr_out      = lr_out_q;
    assign bus.lr_wr_en    = lr_wr_en_q;
    assign bus.depth_count = count;
    assign bus.empty       = is_empty;
    assign bus.full        = is_full;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
endmodule
